// File: rtl/dmem_lsu_pkg.sv
// Shared types for the data-memory path: access sizes (also used by the decoder),
// load/store unit states and the alignment rule.
package risc_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        DONE = 2'b11
    } lsu_state_t;

    // The unused size encoding behaves like WORD, so it needs full word alignment.
    function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] addr_lo);
        case (size)
            BYTE:    is_misaligned = 1'b0;
            HALF:    is_misaligned = addr_lo[0];
            default: is_misaligned = (addr_lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// Byte-lane steering between a 32-bit word bus and sub-word accesses:
// byte enables, store-data replication and load-data extraction/extension.
module lsu_align
    import risc_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  mem_size_t   i_size,
    input  logic        i_zero_extend,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [31:0] w_shifted;

    always_comb begin
        w_shifted = i_rdata >> {i_addr_lo, 3'b000};
        o_be      = 4'b1111;
        o_wdata   = i_wdata;
        o_rdata   = w_shifted;
        case (i_size)
            BYTE: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{~i_zero_extend & w_shifted[7]}}, w_shifted[7:0]};
            end
            HALF: begin
                o_be    = 4'b0011 << i_addr_lo;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = {{16{~i_zero_extend & w_shifted[15]}}, w_shifted[15:0]};
            end
            default: begin
                o_be    = 4'b1111;
                o_wdata = i_wdata;
                o_rdata = w_shifted;
            end
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit: issues one word-aligned byte-enabled bus transaction per memory
// instruction, stalls the pipeline until the response, and returns extended load data.
module dmem_lsu
    import risc_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_ex_req,
    input  logic              i_ex_wr_en,
    input  mem_size_t         i_ex_size,
    input  logic              i_ex_zero_extend,
    input  logic [ADDR_W-1:0] i_ex_addr,
    input  logic [31:0]       i_ex_wdata,
    output logic              o_lsu_busy,
    output logic              o_ld_valid,
    output logic [31:0]       o_ld_data,
    output logic              o_misaligned_exc,
    output logic [ADDR_W-1:0] o_exc_addr,
    output logic              o_bus_req,
    output logic              o_bus_we,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [3:0]        o_bus_be,
    output logic [31:0]       o_bus_wdata,
    input  logic              i_bus_gnt,
    input  logic              i_bus_rvalid,
    input  logic [31:0]       i_bus_rdata
);

    lsu_state_t        r_state;
    lsu_state_t        w_next;
    logic [ADDR_W-1:0] r_addr;
    mem_size_t         r_size;
    logic              r_we;
    logic              r_zext;
    logic              r_exc;
    logic [3:0]        r_be;
    logic [31:0]       r_wdata;
    logic [31:0]       r_ld_data;

    logic              w_accept;
    logic              w_capture_rd;
    logic              w_misaligned;
    logic [1:0]        w_sel_lo;
    mem_size_t         w_sel_size;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [31:0]       w_rdata;

    // One steering unit serves both paths: in IDLE it shapes the incoming store,
    // afterwards it extracts load data using the captured address and size.
    assign w_sel_lo     = (r_state == IDLE) ? i_ex_addr[1:0] : r_addr[1:0];
    assign w_sel_size   = (r_state == IDLE) ? i_ex_size : r_size;
    assign w_misaligned = is_misaligned(i_ex_size, i_ex_addr[1:0]);

    lsu_align u_align (
        .i_addr_lo     (w_sel_lo),
        .i_size        (w_sel_size),
        .i_zero_extend (r_zext),
        .i_wdata       (i_ex_wdata),
        .i_rdata       (i_bus_rdata),
        .o_be          (w_be),
        .o_wdata       (w_wdata),
        .o_rdata       (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next           = r_state;
        w_accept         = 1'b0;
        w_capture_rd     = 1'b0;
        o_lsu_busy       = 1'b0;
        o_bus_req        = 1'b0;
        o_ld_valid       = 1'b0;
        o_misaligned_exc = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_ex_req) begin
                    w_accept   = 1'b1;
                    o_lsu_busy = 1'b1;
                    w_next     = w_misaligned ? DONE : REQ;
                end
            end
            REQ: begin
                o_lsu_busy = 1'b1;
                o_bus_req  = 1'b1;
                if (i_bus_gnt) begin
                    w_next = WAIT;
                end
            end
            WAIT: begin
                o_lsu_busy = 1'b1;
                if (i_bus_rvalid) begin
                    w_capture_rd = 1'b1;
                    w_next       = DONE;
                end
            end
            DONE: begin
                o_ld_valid       = ~r_we & ~r_exc;
                o_misaligned_exc = r_exc;
                w_next           = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr    <= '0;
            r_size    <= BYTE;
            r_we      <= 1'b0;
            r_zext    <= 1'b0;
            r_exc     <= 1'b0;
            r_be      <= 4'b0000;
            r_wdata   <= 32'h0;
            r_ld_data <= 32'h0;
        end else begin
            if (w_accept) begin
                r_addr  <= i_ex_addr;
                r_size  <= i_ex_size;
                r_we    <= i_ex_wr_en;
                r_zext  <= i_ex_zero_extend;
                r_exc   <= w_misaligned;
                r_be    <= w_be;
                r_wdata <= w_wdata;
            end
            if (w_capture_rd) begin
                r_ld_data <= w_rdata;
            end
        end
    end

    // Request fields come straight from registers, so they hold steady while gnt is pending.
    assign o_bus_we    = r_we;
    assign o_bus_addr  = {r_addr[ADDR_W-1:2], 2'b00};
    assign o_bus_be    = r_be;
    assign o_bus_wdata = r_wdata;
    assign o_ld_data   = r_ld_data;
    assign o_exc_addr  = r_addr;

endmodule
